// File: rtl/prio_enc_arb.sv
// Registered N-input priority encoder with a valid/ready output handshake.
// Supports fixed (highest index wins) or round-robin priority via RR_MODE.
module prio_enc_arb #(
  parameter int N       = 8,
  parameter int W       = 3,
  parameter bit RR_MODE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic {IDLE, HOLD} state_e;

  localparam int unsigned     NU   = N;
  localparam logic [W-1:0]    LAST = W'(N-1);

  state_e       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] oh_q, oh_d;
  logic [W-1:0] win;
  logic [N-1:0] win_oh;
  logic         found;
  logic         load;
  logic         hs;
  int unsigned  cand;

  // Round-robin search walks ptr, ptr-1, ... wrapping modulo N, so indices
  // >= N can never be selected even when N is not a power of two.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = 0;
    if (RR_MODE) begin
      for (int unsigned i = 0; i < NU; i++) begin
        cand = 32'(ptr_q) + NU - i;
        if (cand >= NU) cand = cand - NU;
        if (!found && req[cand[W-1:0]]) begin
          win   = cand[W-1:0];
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NU; i++) begin
        if (req[i]) win = W'(i);
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    ptr_d   = ptr_q;
    hs      = (state_q == HOLD) && out_ready;
    load    = en && (|req) && ((state_q == IDLE) || out_ready);

    if (hs && RR_MODE) begin
      ptr_d = (idx_q == '0) ? LAST : idx_q - W'(1);
    end

    // A fresh load selects with the pre-update ptr_q, even on a retiring edge.
    if (load) begin
      state_d = HOLD;
      idx_d   = win;
      oh_d    = win_oh;
    end else if (hs) begin
      state_d = IDLE;
      oh_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      oh_q    <= '0;
      ptr_q   <= LAST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_idx    = idx_q;
  assign out_onehot = oh_q;
  assign out_valid  = (state_q == HOLD);
  assign busy       = (state_q == HOLD);

endmodule

// File: tb/tb_prio_enc_arb.sv
// Scoreboard bench: three instances (fixed N=8, round-robin N=8, round-robin N=5)
// checked against a rule-level reference model with per-instance result queues.
module tb_prio_enc_arb;

  logic       clk = 1'b0;
  logic       rst_n, en, rdy;
  logic [7:0] req;

  logic [2:0] idx0, idx1, idx2;
  logic [7:0] oh0, oh1;
  logic [4:0] oh2;
  logic       v0, v1, v2, b0, b1, b2;

  always #5 clk = ~clk;

  prio_enc_arb #(.N(8), .W(3), .RR_MODE(1'b0)) u_fix8 (
    .clk(clk), .rst_n(rst_n), .req(req), .en(en), .out_idx(idx0),
    .out_onehot(oh0), .out_valid(v0), .out_ready(rdy), .busy(b0));

  prio_enc_arb #(.N(8), .W(3), .RR_MODE(1'b1)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .req(req), .en(en), .out_idx(idx1),
    .out_onehot(oh1), .out_valid(v1), .out_ready(rdy), .busy(b1));

  prio_enc_arb #(.N(5), .W(3), .RR_MODE(1'b1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .req(req[4:0]), .en(en), .out_idx(idx2),
    .out_onehot(oh2), .out_valid(v2), .out_ready(rdy), .busy(b2));

  int tests = 0;
  int fails = 0;

  int NS[3]  = '{8, 8, 5};
  bit RRS[3] = '{1'b0, 1'b1, 1'b1};

  bit m_valid[3] = '{1'b0, 1'b0, 1'b0};
  int m_idx[3]   = '{0, 0, 0};
  int m_ptr[3]   = '{7, 7, 4};
  int q0[$], q1[$], q2[$];

  function automatic int model_win(int n, bit rr, int ptr, logic [7:0] r);
    if (!rr) begin
      for (int k = n - 1; k >= 0; k--) if (r[k]) return k;
    end else begin
      for (int k = 0; k < n; k++) begin
        int j = (ptr - k + n) % n;
        if (r[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic push_q(int u, int w);
    case (u)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic clear_q(int u);
    case (u)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  function automatic int size_q(int u);
    case (u)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int pop_q(int u);
    case (u)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(string name, int u, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s inst=%0d t=%0t actual=%0d expected=%0d", name, u, $time, act, exp);
    end
  endtask

  // Reference model: advances on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      int         n;
      int         nptr;
      int         w;
      bit         hs, ld;
      logic [7:0] r;
      n = NS[u];
      r = req & 8'((1 << n) - 1);
      if (!rst_n) begin
        m_valid[u] = 1'b0;
        m_idx[u]   = 0;
        m_ptr[u]   = n - 1;
        clear_q(u);
      end else begin
        hs   = m_valid[u] && rdy;
        ld   = en && (r != 8'h00) && (!m_valid[u] || rdy);
        nptr = m_ptr[u];
        if (hs && RRS[u]) nptr = (m_idx[u] == 0) ? n - 1 : m_idx[u] - 1;
        if (ld) begin
          w = model_win(n, RRS[u], m_ptr[u], r);
          push_q(u, w);
          m_valid[u] = 1'b1;
          m_idx[u]   = w;
        end else if (hs) begin
          m_valid[u] = 1'b0;
        end
        m_ptr[u] = nptr;
      end
    end
  end

  // Monitor: compares on the falling edge, popping the scoreboard on handshakes.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      int v, b, idx, oh, e;
      case (u)
        0: begin v = int'(v0); b = int'(b0); idx = int'(idx0); oh = int'(oh0); end
        1: begin v = int'(v1); b = int'(b1); idx = int'(idx1); oh = int'(oh1); end
        default: begin v = int'(v2); b = int'(b2); idx = int'(idx2); oh = int'(oh2); end
      endcase
      chk("valid", u, v, int'(m_valid[u]));
      chk("busy", u, b, int'(m_valid[u]));
      if (v == 1 && rdy) begin
        if (size_q(u) == 0) begin
          chk("unexpected_result", u, idx, -1);
        end else begin
          e = pop_q(u);
          chk("idx", u, idx, e);
          chk("onehot", u, oh, 1 << e);
          chk("idx_range", u, int'(idx < NS[u]), 1);
        end
      end else begin
        chk("idx_held", u, idx, m_idx[u]);
        chk("onehot_held", u, oh, (v == 1) ? (1 << m_idx[u]) : 0);
      end
    end
  end

  task automatic drive(bit r, bit e, bit rd, logic [7:0] q, int n);
    rst_n = r;
    en    = e;
    rdy   = rd;
    req   = q;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00, 2);

    // Backpressure: value latched, later req change ignored while held.
    drive(1'b1, 1'b1, 1'b0, 8'h2C, 1);
    drive(1'b1, 1'b1, 1'b0, 8'h80, 4);
    drive(1'b1, 1'b0, 1'b1, 8'h00, 2);

    // Back-to-back streaming.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
    drive(1'b1, 1'b1, 1'b1, 8'h81, 10);
    drive(1'b1, 1'b0, 1'b1, 8'h00, 2);

    // Full rotation from reset pointer.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 9);
    drive(1'b1, 1'b0, 1'b1, 8'h00, 1);

    // N=5 wrap-around patterns.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
    drive(1'b1, 1'b1, 1'b1, 8'h15, 5);
    drive(1'b1, 1'b0, 1'b1, 8'h00, 1);
    drive(1'b1, 1'b1, 1'b1, 8'h01, 4);
    drive(1'b1, 1'b0, 1'b1, 8'h00, 1);

    // Zero request and disabled encode.
    drive(1'b1, 1'b1, 1'b1, 8'h00, 10);
    drive(1'b1, 1'b0, 1'b1, 8'hFF, 10);

    // Reset while holding a result with an advanced pointer.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 4);
    drive(1'b1, 1'b1, 1'b0, 8'hFF, 2);
    drive(1'b0, 1'b1, 1'b0, 8'hFF, 1);
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 2);
    drive(1'b1, 1'b0, 1'b1, 8'h00, 1);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), r, 1);
    end

    drive(1'b1, 1'b0, 1'b1, 8'h00, 3);
    @(negedge clk);
    #1;
    for (int u = 0; u < 3; u++) chk("queue_drained", u, size_q(u), int'(m_valid[u]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
